// File: rtl/math_pipelined_div.sv
// Unsigned restoring divider: each trial subtraction ripples through
// ALU_WIDTH-bit chunks, one chunk per cycle, with a registered borrow.
module math_pipelined_div #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int AW = (WIDTH + LATENCY - 1) / LATENCY;
  localparam int CC = (WIDTH + AW - 1) / AW;
  localparam int PW = CC * AW;
  localparam int CW = (CC > 1) ? $clog2(CC) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] r;
  logic             dz;
  logic [BW-1:0]    bcnt;
  logic [CW-1:0]    ccnt;
  logic             borrow;
  logic [AW-1:0]    diff [CC];

  logic [WIDTH:0]   t;
  logic [PW-1:0]    t_pad;
  logic [PW-1:0]    d_pad;
  logic [PW-1:0]    dres;
  logic [AW-1:0]    tch [CC];
  logic [AW-1:0]    dch [CC];
  logic [AW:0]      csub;
  logic             last;
  logic             no_borrow;
  logic [WIDTH-1:0] r_nxt;

  assign t = {r, q[WIDTH-1]};

  always_comb begin
    t_pad = '0;
    d_pad = '0;
    t_pad[WIDTH-1:0] = t[WIDTH-1:0];
    d_pad[WIDTH-1:0] = d;
    for (int i = 0; i < CC; i++) begin
      tch[i] = t_pad[i*AW +: AW];
      dch[i] = d_pad[i*AW +: AW];
    end
  end

  // Zero-padded top chunk keeps the borrow-out identical to a narrower one
  assign csub = {1'b0, tch[ccnt]} - {1'b0, dch[ccnt]}
              - {{AW{1'b0}}, borrow};

  always_comb begin
    dres = '0;
    for (int i = 0; i < CC; i++)
      dres[i*AW +: AW] = (CW'(i) == ccnt) ? csub[AW-1:0] : diff[i];
  end

  assign last      = (ccnt == CW'(CC - 1));
  assign no_borrow = t[WIDTH] | ~csub[AW];
  assign r_nxt     = no_borrow ? dres[WIDTH-1:0] : t[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      dz          <= 1'b0;
      bcnt        <= '0;
      ccnt        <= '0;
      borrow      <= 1'b0;
      for (int i = 0; i < CC; i++) diff[i] <= '0;
    end else if (ce) begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            d        <= divisor;
            bcnt     <= BW'(WIDTH - 1);
            ccnt     <= '0;
            borrow   <= 1'b0;
            if (divisor == '0) begin
              q     <= '1;
              r     <= dividend;
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              q     <= dividend;
              r     <= '0;
              dz    <= 1'b0;
              state <= SUB;
            end
          end
        end
        SUB: begin
          if (!last) begin
            diff[ccnt] <= csub[AW-1:0];
            borrow     <= csub[AW];
            ccnt       <= ccnt + 1'b1;
          end else begin
            borrow <= 1'b0;
            ccnt   <= '0;
            r      <= r_nxt;
            q      <= {q[WIDTH-2:0], no_borrow};
            if (bcnt == '0) state <= DONE;
            else bcnt <= bcnt - 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid   <= 1'b1;
            quotient    <= q;
            remainder   <= r;
            div_by_zero <= dz;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_math_pipelined_div.sv
// Directed and randomized checks of math_pipelined_div across
// several WIDTH/LATENCY configurations.
module tb_math_pipelined_div;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  logic [12:0] sw_a;
  logic [12:0] sw_b;
  logic [3:0]  sw_iv;
  logic [3:0]  sw_ir;
  logic [3:0]  sw_ov;
  logic [3:0]  sw_dz;
  logic [7:0]  q8 [3];
  logic [7:0]  r8 [3];
  logic [12:0] q13;
  logic [12:0] r13;
  logic        one = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  math_pipelined_div #(.WIDTH(8), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  math_pipelined_div #(.WIDTH(8), .LATENCY(1)) s1 (
    .clk(clk), .rst_n(rst_n), .ce(one),
    .in_valid(sw_iv[0]), .in_ready(sw_ir[0]),
    .dividend(sw_a[7:0]), .divisor(sw_b[7:0]),
    .out_valid(sw_ov[0]), .out_ready(one),
    .quotient(q8[0]), .remainder(r8[0]),
    .div_by_zero(sw_dz[0])
  );

  math_pipelined_div #(.WIDTH(8), .LATENCY(3)) s3 (
    .clk(clk), .rst_n(rst_n), .ce(one),
    .in_valid(sw_iv[1]), .in_ready(sw_ir[1]),
    .dividend(sw_a[7:0]), .divisor(sw_b[7:0]),
    .out_valid(sw_ov[1]), .out_ready(one),
    .quotient(q8[1]), .remainder(r8[1]),
    .div_by_zero(sw_dz[1])
  );

  math_pipelined_div #(.WIDTH(8), .LATENCY(8)) s8 (
    .clk(clk), .rst_n(rst_n), .ce(one),
    .in_valid(sw_iv[2]), .in_ready(sw_ir[2]),
    .dividend(sw_a[7:0]), .divisor(sw_b[7:0]),
    .out_valid(sw_ov[2]), .out_ready(one),
    .quotient(q8[2]), .remainder(r8[2]),
    .div_by_zero(sw_dz[2])
  );

  math_pipelined_div #(.WIDTH(13), .LATENCY(4)) s13 (
    .clk(clk), .rst_n(rst_n), .ce(one),
    .in_valid(sw_iv[3]), .in_ready(sw_ir[3]),
    .dividend(sw_a), .divisor(sw_b),
    .out_valid(sw_ov[3]), .out_ready(one),
    .quotient(q13), .remainder(r13),
    .div_by_zero(sw_dz[3])
  );

  // Called just after a clock edge with the DUT idle
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        input int ce_at, output int lat,
                        output logic rdy_hi);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    rdy_hi   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'hxx;
    divisor  = 8'hxx;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (n == ce_at) ce = 1'b0;
      if (n == ce_at + 3) ce = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
      if (in_ready) rdy_hi = 1'b1;
    end
    ce = 1'b1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs got rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    total++;
    if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got q=%0d r=%0d dz=%b want 0 0 0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int   lat;
    logic rh;
    do_div(8'd100, 8'd7, 0, lat, rh);
    total++;
    if (lat !== 17) begin
      bad++;
      $display("FAIL basic_lat got %0d want 17", lat);
    end
    total++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_val got q=%0d r=%0d dz=%b want 14 2 0",
               quotient, remainder, div_by_zero);
    end
    total++;
    if (rh !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_rdy got busy_rdy=%b rdy=%b want 0 0", rh, in_ready);
    end
    consume();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_cons got ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_bounds();
    logic [7:0] va [4] = '{8'd255, 8'd7,   8'd255, 8'd0};
    logic [7:0] vb [4] = '{8'd1,   8'd200, 8'd255, 8'd9};
    logic [7:0] vq [4] = '{8'd255, 8'd0,   8'd1,   8'd0};
    logic [7:0] vr [4] = '{8'd0,   8'd7,   8'd0,   8'd0};
    int   lat;
    logic rh;
    for (int i = 0; i < 4; i++) begin
      do_div(va[i], vb[i], 0, lat, rh);
      total++;
      if (lat !== 17 || quotient !== vq[i] || remainder !== vr[i]) begin
        bad++;
        $display("FAIL bound%0d got lat=%0d q=%0d r=%0d want 17 %0d %0d",
                 i, lat, quotient, remainder, vq[i], vr[i]);
      end
      consume();
    end
  endtask

  task automatic test_div_zero();
    int   lat;
    logic rh;
    do_div(8'd5, 8'd0, 0, lat, rh);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL dz_lat got %0d want 1", lat);
    end
    total++;
    if (quotient !== 8'd255 || remainder !== 8'd5 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dz_val got q=%0d r=%0d dz=%b want 255 5 1",
               quotient, remainder, div_by_zero);
    end
    consume();
    do_div(8'd9, 8'd3, 0, lat, rh);
    total++;
    if (lat !== 17 || quotient !== 8'd3 || remainder !== 8'd0
        || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL dz_next got lat=%0d q=%0d r=%0d dz=%b want 17 3 0 0",
               lat, quotient, remainder, div_by_zero);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int   lat;
    logic rh;
    do_div(8'd100, 8'd7, 0, lat, rh);
    in_valid = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0
          || quotient !== 8'd14 || remainder !== 8'd2) begin
        bad++;
        $display("FAIL hold%0d got ov=%b rdy=%b q=%0d r=%0d want 1 0 14 2",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL both_hs got ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL no_accept got rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ce();
    int   lat;
    logic rh;
    do_div(8'd100, 8'd7, 5, lat, rh);
    total++;
    if (lat !== 20 || quotient !== 8'd14 || remainder !== 8'd2) begin
      bad++;
      $display("FAIL ce_stall got lat=%0d q=%0d r=%0d want 20 14 2",
               lat, quotient, remainder);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic rh;
    dividend = 8'd200;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0
        || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst got rdy=%b ov=%b q=%0d r=%0d dz=%b want 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_div(8'd200, 8'd3, 0, lat, rh);
    total++;
    if (lat !== 17 || quotient !== 8'd66 || remainder !== 8'd2) begin
      bad++;
      $display("FAIL after_rst got lat=%0d q=%0d r=%0d want 17 66 2",
               lat, quotient, remainder);
    end
    consume();
  endtask

  task automatic test_sweep(input int idx, input int runs);
    int exp_lat [4] = '{9, 25, 65, 53};
    int w;
    int a;
    int b;
    int lat;
    int gq;
    int gr;
    w = (idx == 3) ? 13 : 8;
    for (int k = 0; k < runs; k++) begin
      a = int'($urandom_range(0, (1 << w) - 1));
      b = (k < 2) ? ((k == 0) ? 1 : (1 << w) - 1)
                  : int'($urandom_range(1, (1 << w) - 1));
      sw_a = 13'(a);
      sw_b = 13'(b);
      sw_iv[idx] = 1'b1;
      @(posedge clk);
      #1;
      sw_iv[idx] = 1'b0;
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
        @(posedge clk);
        #1;
        if (sw_ov[idx]) begin
          lat = n;
          break;
        end
      end
      gq = (idx == 3) ? int'(q13) : int'(q8[idx]);
      gr = (idx == 3) ? int'(r13) : int'(r8[idx]);
      total++;
      if (lat != exp_lat[idx] || gq != a / b || gr != a % b
          || sw_dz[idx] !== 1'b0) begin
        bad++;
        $display("FAIL sweep%0d %0d/%0d got lat=%0d q=%0d r=%0d dz=%b want %0d %0d %0d 0",
                 idx, a, b, lat, gq, gr, sw_dz[idx], exp_lat[idx], a / b, a % b);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    sw_a      = '0;
    sw_b      = '0;
    sw_iv     = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_bounds();
    test_div_zero();
    test_backpressure();
    test_ce();
    test_reset_mid();
    for (int i = 0; i < 4; i++) test_sweep(i, 200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
